// File: rtl/rheed_frame_ctrl_if.sv
// Pipeline control/monitor bundle between the frame sequencer and the crop/normalise pipeline.
//   ap_start   : start request from the sequencer
//   ap_ready   : start acknowledge from the pipeline (AND of all crop_norm ap_ready)
//   out_tvalid : monitored pipeline output valid
//   out_tready : monitored pipeline output ready
// master = sequencer side, slave = pipeline/monitor side.
interface rheed_frame_ctrl_if;
   logic ap_start;
   logic ap_ready;
   logic out_tvalid;
   logic out_tready;

   modport master (
      output ap_start,
      input  ap_ready,
      input  out_tvalid,
      input  out_tready
   );

   modport slave (
      input  ap_start,
      output ap_ready,
      output out_tvalid,
      output out_tready
   );
endinterface

// File: rtl/rheed_frame_ctrl.sv
// Per-frame sequencer for the RHEED crop/normalise inference pipeline.
// Double-buffers crop coordinates (host-written shadow set, active set applied
// at the frame boundary), issues one ap_start per accepted frame, counts output
// beats to detect frame completion, and runs a watchdog plus drop/frame counters.
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   enable, frame_sof     : frame acceptance enable, start-of-frame pulse
//   cfg_wr_*              : shadow coordinate write (index, x0, y0)
//   cfg_commit            : mark shadow set pending for the next frame
//   err_clr               : clear the sticky timeout flag
//   pipe                  : ap_start/ap_ready handshake and monitored output beats
//   crop_x0, crop_y0      : active coordinate arrays
//   busy, abort           : not-idle status, watchdog-expiry pulse
//   frame_cnt, drop_cnt   : completed frames (wraps), dropped frames (saturates)
//   timeout_err           : sticky watchdog flag
module rheed_frame_ctrl #(
   parameter  int unsigned IN_ROWS        = 20,
   parameter  int unsigned IN_COLS        = 20,
   parameter  int unsigned OUT_ROWS       = 20,
   parameter  int unsigned OUT_COLS       = 20,
   parameter  int unsigned NUM_CROPS      = 3,
   parameter  int unsigned TIMEOUT_CYCLES = 4096,
   localparam int unsigned IDX_W          = (NUM_CROPS > 1) ? $clog2(NUM_CROPS) : 1,
   localparam int unsigned X_W            = $clog2(IN_COLS),
   localparam int unsigned Y_W            = $clog2(IN_ROWS)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           enable,
   input  logic                           frame_sof,
   input  logic                           cfg_wr_en,
   input  logic [IDX_W-1:0]               cfg_wr_idx,
   input  logic [X_W-1:0]                 cfg_wr_x0,
   input  logic [Y_W-1:0]                 cfg_wr_y0,
   input  logic                           cfg_commit,
   input  logic                           err_clr,
   rheed_frame_ctrl_if.master             pipe,
   output logic [NUM_CROPS-1:0][X_W-1:0]  crop_x0,
   output logic [NUM_CROPS-1:0][Y_W-1:0]  crop_y0,
   output logic                           busy,
   output logic                           abort,
   output logic [15:0]                    frame_cnt,
   output logic [15:0]                    drop_cnt,
   output logic                           timeout_err
);

   localparam int unsigned BEATS  = NUM_CROPS * OUT_ROWS * OUT_COLS;
   localparam int unsigned BEAT_W = $clog2(BEATS + 1);
   localparam int unsigned WD_W   = $clog2(TIMEOUT_CYCLES);
   localparam int unsigned X_MAX  = IN_COLS - OUT_COLS;
   localparam int unsigned Y_MAX  = IN_ROWS - OUT_ROWS;

   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
   localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      START = 2'd2,
      RUN   = 2'd3
   } state_t;

   state_t                         state_q,     state_d;
   logic [NUM_CROPS-1:0][X_W-1:0]  shadow_x_q,  shadow_x_d;
   logic [NUM_CROPS-1:0][Y_W-1:0]  shadow_y_q,  shadow_y_d;
   logic [NUM_CROPS-1:0][X_W-1:0]  crop_x0_d;
   logic [NUM_CROPS-1:0][Y_W-1:0]  crop_y0_d;
   logic                           pending_q,   pending_d;
   logic                           ap_start_q,  ap_start_d;
   logic [BEAT_W-1:0]              beat_cnt,    beat_cnt_d;
   logic [WD_W-1:0]                wd_cnt,      wd_cnt_d;
   logic                           busy_d, abort_d, timeout_err_d;
   logic [15:0]                    frame_cnt_d, drop_cnt_d;
   logic [X_W-1:0]                 wr_x_clamp;
   logic [Y_W-1:0]                 wr_y_clamp;
   logic                           beat;
   logic                           expire;

   assign pipe.ap_start = ap_start_q;
   assign beat          = pipe.out_tvalid && pipe.out_tready;

   // State and all outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         shadow_x_q  <= '0;
         shadow_y_q  <= '0;
         crop_x0     <= '0;
         crop_y0     <= '0;
         pending_q   <= 1'b0;
         ap_start_q  <= 1'b0;
         beat_cnt    <= '0;
         wd_cnt      <= '0;
         busy        <= 1'b0;
         abort       <= 1'b0;
         frame_cnt   <= '0;
         drop_cnt    <= '0;
         timeout_err <= 1'b0;
      end else begin
         state_q     <= state_d;
         shadow_x_q  <= shadow_x_d;
         shadow_y_q  <= shadow_y_d;
         crop_x0     <= crop_x0_d;
         crop_y0     <= crop_y0_d;
         pending_q   <= pending_d;
         ap_start_q  <= ap_start_d;
         beat_cnt    <= beat_cnt_d;
         wd_cnt      <= wd_cnt_d;
         busy        <= busy_d;
         abort       <= abort_d;
         frame_cnt   <= frame_cnt_d;
         drop_cnt    <= drop_cnt_d;
         timeout_err <= timeout_err_d;
      end
   end

   // Next-state, shadow/active coordinates, watchdog and counters
   always_comb begin
      state_d       = state_q;
      shadow_x_d    = shadow_x_q;
      shadow_y_d    = shadow_y_q;
      crop_x0_d     = crop_x0;
      crop_y0_d     = crop_y0;
      pending_d     = pending_q;
      ap_start_d    = ap_start_q;
      beat_cnt_d    = beat_cnt;
      wd_cnt_d      = wd_cnt;
      abort_d       = 1'b0;
      frame_cnt_d   = frame_cnt;
      drop_cnt_d    = drop_cnt;
      timeout_err_d = timeout_err;
      expire        = 1'b0;
      wr_x_clamp    = (32'(cfg_wr_x0) > X_MAX) ? X_W'(X_MAX) : cfg_wr_x0;
      wr_y_clamp    = (32'(cfg_wr_y0) > Y_MAX) ? Y_W'(Y_MAX) : cfg_wr_y0;

      // Out-of-range indices match no entry and are dropped
      if (cfg_wr_en) begin
         for (int unsigned i = 0; i < NUM_CROPS; i++) begin
            if (32'(cfg_wr_idx) == i) begin
               shadow_x_d[i] = wr_x_clamp;
               shadow_y_d[i] = wr_y_clamp;
            end
         end
      end

      // Cleared first so a same-cycle expiry below keeps the flag set
      if (err_clr) timeout_err_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (frame_sof && enable) state_d = LOAD;
         end
         LOAD: begin
            // Copies the registered shadow, so a same-cycle write lands next frame
            if (pending_q) begin
               crop_x0_d = shadow_x_q;
               crop_y0_d = shadow_y_q;
               pending_d = 1'b0;
            end
            wd_cnt_d   = '0;
            ap_start_d = 1'b1;
            state_d    = START;
         end
         START: begin
            if (ap_start_q && pipe.ap_ready) begin
               ap_start_d = 1'b0;
               wd_cnt_d   = '0;
               state_d    = RUN;
            end else if (wd_cnt == WD_LAST) begin
               expire = 1'b1;
            end else begin
               wd_cnt_d = wd_cnt + WD_W'(1);
            end
         end
         RUN: begin
            if (beat) begin
               wd_cnt_d = '0;
               if (beat_cnt == BEAT_LAST) begin
                  beat_cnt_d  = '0;
                  frame_cnt_d = frame_cnt + 16'd1;
                  state_d     = IDLE;
               end else begin
                  beat_cnt_d = beat_cnt + BEAT_W'(1);
               end
            end else if (wd_cnt == WD_LAST) begin
               expire = 1'b1;
            end else begin
               wd_cnt_d = wd_cnt + WD_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (expire) begin
         state_d       = IDLE;
         ap_start_d    = 1'b0;
         beat_cnt_d    = '0;
         wd_cnt_d      = '0;
         abort_d       = 1'b1;
         timeout_err_d = 1'b1;
      end

      // Commit wins over the LOAD-cycle clear
      if (cfg_commit) pending_d = 1'b1;

      // No queueing: any sof while not idle is a drop
      if (frame_sof && (state_q != IDLE) && (drop_cnt != 16'hFFFF))
         drop_cnt_d = drop_cnt + 16'd1;

      busy_d = (state_d != IDLE);
   end

endmodule

// File: tb/tb_rheed_frame_ctrl.sv
module tb_rheed_frame_ctrl;

   localparam int NC    = 3;
   localparam int BEATS = 1200;
   localparam int LIM   = 12;   // 32x32 input, 20x20 crop
   localparam int TO    = 4096;

   typedef struct {
      logic [2:0][4:0] x;
      logic [2:0][4:0] y;
      logic [15:0]     fc;
   } frame_exp_t;

   logic            clk = 1'b0;
   logic            reset;
   logic            enable;
   logic            frame_sof;
   logic            cfg_wr_en;
   logic [1:0]      cfg_wr_idx;
   logic [4:0]      cfg_wr_x0;
   logic [4:0]      cfg_wr_y0;
   logic            cfg_commit;
   logic            err_clr;
   logic [2:0][4:0] crop_x0;
   logic [2:0][4:0] crop_y0;
   logic            busy;
   logic            abort;
   logic [15:0]     frame_cnt;
   logic [15:0]     drop_cnt;
   logic            timeout_err;

   rheed_frame_ctrl_if pif ();

   rheed_frame_ctrl #(
      .IN_ROWS(32), .IN_COLS(32), .OUT_ROWS(20), .OUT_COLS(20),
      .NUM_CROPS(3), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .frame_sof(frame_sof),
      .cfg_wr_en(cfg_wr_en), .cfg_wr_idx(cfg_wr_idx), .cfg_wr_x0(cfg_wr_x0),
      .cfg_wr_y0(cfg_wr_y0), .cfg_commit(cfg_commit), .err_clr(err_clr),
      .pipe(pif), .crop_x0(crop_x0), .crop_y0(crop_y0), .busy(busy),
      .abort(abort), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model
   logic [2:0][4:0] sh_x, sh_y, act_x, act_y;
   bit              pending;
   int              exp_frames, exp_drops;
   frame_exp_t      sb[$];

   function automatic void model_reset();
      sh_x = '0; sh_y = '0; act_x = '0; act_y = '0;
      pending = 1'b0; exp_frames = 0; exp_drops = 0;
      sb.delete();
   endfunction

   function automatic void model_write(int idx, int x, int y);
      if (idx < NC) begin
         sh_x[2'(idx)] = 5'((x > LIM) ? LIM : x);
         sh_y[2'(idx)] = 5'((y > LIM) ? LIM : y);
      end
   endfunction

   function automatic void model_load_push(bit push);
      frame_exp_t e;
      if (pending) begin
         act_x = sh_x; act_y = sh_y; pending = 1'b0;
      end
      if (push) begin
         e.x = act_x; e.y = act_y; e.fc = 16'(exp_frames + 1 + sb.size());
         sb.push_back(e);
      end
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic write_cfg(int idx, int x, int y);
      cfg_wr_en = 1'b1; cfg_wr_idx = 2'(idx); cfg_wr_x0 = 5'(x); cfg_wr_y0 = 5'(y);
      tick();
      cfg_wr_en = 1'b0;
      model_write(idx, x, y);
   endtask

   task automatic commit();
      cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
      pending = 1'b1;
   endtask

   task automatic run_beats(input int n, input bit rnd, output int got);
      int cyc = 0;
      got = 0;
      while (got < n && cyc < 20 * n + 100) begin
         pif.out_tvalid = 1'b1;
         pif.out_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         tick();
         cyc++;
         if (pif.out_tready) got++;
      end
      pif.out_tvalid = 1'b0;
      pif.out_tready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; enable = 1'b1; frame_sof = 1'b0; cfg_wr_en = 1'b0;
      cfg_wr_idx = '0; cfg_wr_x0 = '0; cfg_wr_y0 = '0; cfg_commit = 1'b0; err_clr = 1'b0;
      pif.ap_ready = 1'b0; pif.out_tvalid = 1'b0; pif.out_tready = 1'b0;
      model_reset();
      repeat (3) tick();
      n_checks++;
      if ({busy, pif.ap_start, abort, timeout_err, frame_cnt, drop_cnt, crop_x0, crop_y0} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h required 0",
                  {busy, pif.ap_start, abort, timeout_err, frame_cnt, drop_cnt, crop_x0, crop_y0});
      end
      reset = 1'b1;
      repeat (2) tick();
   endtask

   task automatic test_load_start();
      write_cfg(0, 2, 3);
      write_cfg(1, 5, 5);
      write_cfg(2, 9, 1);
      commit();
      pif.ap_ready = 1'b0;
      frame_sof = 1'b1; tick(); frame_sof = 1'b0;
      model_load_push(1'b1);
      n_checks++;
      if ({busy, pif.ap_start} !== 2'b10) begin
         n_fail++; $display("FAIL load_cycle busy/ap_start: got %b required 10", {busy, pif.ap_start});
      end
      tick();
      n_checks++;
      if (pif.ap_start !== 1'b1) begin
         n_fail++; $display("FAIL ap_start_latency: got %b required 1", pif.ap_start);
      end
      n_checks++;
      if ({crop_x0, crop_y0} !== {act_x, act_y}) begin
         n_fail++; $display("FAIL active_after_load: got %h required %h", {crop_x0, crop_y0}, {act_x, act_y});
      end
   endtask

   task automatic test_ready_stall();
      int hi = 1;
      int got;
      frame_exp_t e;
      for (int i = 2; i <= 11; i++) begin
         tick();
         if (i == 11) pif.ap_ready = 1'b1;
         if (pif.ap_start === 1'b1) hi++;
      end
      tick();
      n_checks++;
      if (hi != 11 || pif.ap_start !== 1'b0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL ap_start_hold: got %0d cycles ap_start=%b busy=%b required 11 0 1", hi, pif.ap_start, busy);
      end
      run_beats(BEATS - 1, 1'b1, got);
      n_checks++;
      if (got != BEATS - 1 || busy !== 1'b1) begin
         n_fail++; $display("FAIL busy_before_last_beat: got beats=%0d busy=%b required %0d 1", got, busy, BEATS - 1);
      end
      run_beats(1, 1'b1, got);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL busy_after_frame: got %b required 0", busy);
      end
      n_checks++;
      if (sb.size() == 0) begin
         n_fail++; $display("FAIL scoreboard_empty: got 0 entries required 1");
      end else begin
         e = sb.pop_front();
         n_checks++;
         if (frame_cnt !== e.fc) begin
            n_fail++; $display("FAIL frame_cnt_stall: got %0d required %0d", frame_cnt, e.fc);
         end
         n_checks++;
         if ({crop_x0, crop_y0} !== {e.x, e.y}) begin
            n_fail++; $display("FAIL crops_stable_stall: got %h required %h", {crop_x0, crop_y0}, {e.x, e.y});
         end
         exp_frames = int'(e.fc);
      end
   endtask

   task automatic test_clamp();
      int got;
      frame_exp_t e;
      write_cfg(1, 19, 19);
      write_cfg(3, 7, 7);
      write_cfg(0, 12, 11);
      write_cfg(2, 13, 0);
      commit();
      pif.ap_ready = 1'b1;
      frame_sof = 1'b1; tick(); frame_sof = 1'b0;
      model_load_push(1'b1);
      tick();
      n_checks++;
      if ({crop_x0, crop_y0} !== {act_x, act_y}) begin
         n_fail++; $display("FAIL clamp_active: got %h required %h", {crop_x0, crop_y0}, {act_x, act_y});
      end
      tick();
      run_beats(BEATS, 1'b0, got);
      n_checks++;
      if (sb.size() == 0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL clamp_frame_done: got busy=%b entries=%0d required 0 1", busy, sb.size());
      end else begin
         e = sb.pop_front();
         n_checks++;
         if (frame_cnt !== e.fc) begin
            n_fail++; $display("FAIL frame_cnt_clamp: got %0d required %0d", frame_cnt, e.fc);
         end
         exp_frames = int'(e.fc);
      end
   endtask

   task automatic test_drops();
      int got;
      frame_exp_t e;
      pif.ap_ready = 1'b1;
      frame_sof = 1'b1; tick(); frame_sof = 1'b0;
      model_load_push(1'b1);
      tick(); tick();
      run_beats(100, 1'b0, got);
      for (int k = 0; k < 3; k++) begin
         frame_sof = 1'b1; tick(); frame_sof = 1'b0; tick();
         if (exp_drops < 16'hFFFF) exp_drops++;
      end
      n_checks++;
      if (drop_cnt !== 16'(exp_drops) || busy !== 1'b1) begin
         n_fail++; $display("FAIL drops_mid_run: got drop=%0d busy=%b required %0d 1", drop_cnt, busy, exp_drops);
      end
      run_beats(BEATS - 100, 1'b0, got);
      n_checks++;
      if (sb.size() == 0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL drop_frame_done: got busy=%b entries=%0d required 0 1", busy, sb.size());
      end else begin
         e = sb.pop_front();
         n_checks++;
         if (frame_cnt !== e.fc) begin
            n_fail++; $display("FAIL frame_cnt_drops: got %0d required %0d", frame_cnt, e.fc);
         end
         exp_frames = int'(e.fc);
      end
      enable = 1'b0;
      frame_sof = 1'b1; tick(); frame_sof = 1'b0;
      tick(); tick();
      n_checks++;
      if ({busy, pif.ap_start} !== 2'b00 || drop_cnt !== 16'(exp_drops)) begin
         n_fail++; $display("FAIL sof_disabled: got busy/ap_start=%b drop=%0d required 00 %0d",
                            {busy, pif.ap_start}, drop_cnt, exp_drops);
      end
      enable = 1'b1;
   endtask

   task automatic test_back_to_back();
      int got;
      frame_exp_t e;
      pif.ap_ready = 1'b1;
      frame_sof = 1'b1; tick(); frame_sof = 1'b0;
      model_load_push(1'b1);
      tick(); tick();
      write_cfg(0, 1, 2);
      commit();
      run_beats(BEATS - 1, 1'b0, got);
      // final beat coincides with a new sof
      pif.out_tvalid = 1'b1; pif.out_tready = 1'b1; frame_sof = 1'b1;
      tick();
      pif.out_tvalid = 1'b0; pif.out_tready = 1'b0; frame_sof = 1'b0;
      if (exp_drops < 16'hFFFF) exp_drops++;
      n_checks++;
      if (busy !== 1'b0 || drop_cnt !== 16'(exp_drops)) begin
         n_fail++; $display("FAIL sof_on_last_beat: got busy=%b drop=%0d required 0 %0d", busy, drop_cnt, exp_drops);
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         n_checks++;
         if (frame_cnt !== e.fc) begin
            n_fail++; $display("FAIL frame_cnt_b2b: got %0d required %0d", frame_cnt, e.fc);
         end
         exp_frames = int'(e.fc);
      end
      // immediate accepted frame; write and commit land in its LOAD cycle
      frame_sof = 1'b1; tick(); frame_sof = 1'b0;
      model_load_push(1'b1);
      cfg_wr_en = 1'b1; cfg_wr_idx = 2'd0; cfg_wr_x0 = 5'd3; cfg_wr_y0 = 5'd4; cfg_commit = 1'b1;
      tick();
      cfg_wr_en = 1'b0; cfg_commit = 1'b0;
      model_write(0, 3, 4);
      pending = 1'b1;
      n_checks++;
      if (pif.ap_start !== 1'b1 || {crop_x0, crop_y0} !== {act_x, act_y}) begin
         n_fail++; $display("FAIL load_pre_write: got ap_start=%b crops=%h required 1 %h",
                            pif.ap_start, {crop_x0, crop_y0}, {act_x, act_y});
      end
      tick();
      run_beats(BEATS, 1'b0, got);
      n_checks++;
      if (sb.size() == 0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL b2b_second_done: got busy=%b entries=%0d required 0 1", busy, sb.size());
      end else begin
         e = sb.pop_front();
         n_checks++;
         if (frame_cnt !== e.fc) begin
            n_fail++; $display("FAIL frame_cnt_b2b2: got %0d required %0d", frame_cnt, e.fc);
         end
         exp_frames = int'(e.fc);
      end
   endtask

   task automatic test_watchdog();
      int  n = 0;
      bit  seen = 1'b0;
      pif.ap_ready = 1'b1;
      frame_sof = 1'b1; tick(); frame_sof = 1'b0;
      model_load_push(1'b0);
      tick();
      n_checks++;
      if ({crop_x0, crop_y0} !== {act_x, act_y}) begin
         n_fail++; $display("FAIL commit_in_load_kept: got %h required %h", {crop_x0, crop_y0}, {act_x, act_y});
      end
      tick();
      err_clr = 1'b1;   // held through expiry: the set must win
      while (!seen && n < TO + 200) begin
         tick();
         n++;
         if (abort === 1'b1) seen = 1'b1;
      end
      err_clr = 1'b0;
      n_checks++;
      if (n != TO) begin
         n_fail++; $display("FAIL watchdog_cycles: got %0d required %0d", n, TO);
      end
      n_checks++;
      if ({busy, pif.ap_start, timeout_err} !== 3'b001 || frame_cnt !== 16'(exp_frames)) begin
         n_fail++; $display("FAIL watchdog_state: got busy/ap_start/err=%b frames=%0d required 001 %0d",
                            {busy, pif.ap_start, timeout_err}, frame_cnt, exp_frames);
      end
      tick();
      n_checks++;
      if ({abort, timeout_err} !== 2'b01) begin
         n_fail++; $display("FAIL abort_pulse: got abort/err=%b required 01", {abort, timeout_err});
      end
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      n_checks++;
      if (timeout_err !== 1'b0) begin
         n_fail++; $display("FAIL err_clr: got %b required 0", timeout_err);
      end
   endtask

   task automatic test_reset_mid_frame();
      int got;
      frame_exp_t e;
      pif.ap_ready = 1'b1;
      frame_sof = 1'b1; tick(); frame_sof = 1'b0;
      model_load_push(1'b0);
      tick(); tick();
      run_beats(600, 1'b0, got);
      #2 reset = 1'b0;
      #1;
      model_reset();
      n_checks++;
      if ({busy, pif.ap_start, abort, timeout_err, frame_cnt, drop_cnt, crop_x0, crop_y0} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_frame: got %h required 0",
                  {busy, pif.ap_start, abort, timeout_err, frame_cnt, drop_cnt, crop_x0, crop_y0});
      end
      tick();
      reset = 1'b1;
      tick();
      write_cfg(2, 4, 4);
      commit();
      frame_sof = 1'b1; tick(); frame_sof = 1'b0;
      model_load_push(1'b1);
      tick();
      n_checks++;
      if ({crop_x0, crop_y0} !== {act_x, act_y}) begin
         n_fail++; $display("FAIL shadow_after_reset: got %h required %h", {crop_x0, crop_y0}, {act_x, act_y});
      end
      tick();
      run_beats(BEATS - 1, 1'b0, got);
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++; $display("FAIL beat_cnt_cleared: got busy=%b required 1", busy);
      end
      run_beats(1, 1'b0, got);
      n_checks++;
      if (sb.size() == 0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL post_reset_done: got busy=%b entries=%0d required 0 1", busy, sb.size());
      end else begin
         e = sb.pop_front();
         n_checks++;
         if (frame_cnt !== e.fc) begin
            n_fail++; $display("FAIL frame_cnt_post_reset: got %0d required %0d", frame_cnt, e.fc);
         end
         exp_frames = int'(e.fc);
      end
   endtask

   initial begin
      test_reset();
      test_load_start();
      test_ready_stall();
      test_clamp();
      test_drops();
      test_back_to_back();
      test_watchdog();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no completion required completion");
      $fatal(1);
   end

endmodule
